// File: rtl/dct_row_mac_sequencer.sv
// Row feeder/accumulator for the sequential Booth multiplier in the 8-point DCT.
// Optional output rounding: define DCT_OUT_ROUND_EN to enable (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT.
module dct_row_mac_sequencer #(
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 8,
  parameter int PROD_W    = 16,
  parameter int ACC_W     = 19,
  parameter int OUT_SHIFT = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [5:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              mul_start,
  output logic [DATA_W-1:0] mul_a,
  output logic [COEF_W-1:0] mul_b,
  input  logic              mul_done,
  input  logic [PROD_W-1:0] mul_prod,
  output logic              mul_rst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [2:0]        out_idx,
  output logic              busy
);

  typedef enum logic [2:0] {S_LOAD, S_FETCH, S_START, S_WAIT, S_ACC, S_EMIT} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             n_q, n_d, k_q, k_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [7:0][DATA_W-1:0] smp_q, smp_d;
  logic                   in_ready_q, in_ready_d;
  logic [5:0]             coef_addr_q, coef_addr_d;
  logic                   mul_start_q, mul_start_d;
  logic [DATA_W-1:0]      mul_a_q, mul_a_d;
  logic [COEF_W-1:0]      mul_b_q, mul_b_d;
  logic                   mul_rst_q, mul_rst_d;
  logic                   out_valid_q, out_valid_d;
  logic [ACC_W-1:0]       out_data_q, out_data_d;
  logic [2:0]             out_idx_q, out_idx_d;
  logic                   busy_q, busy_d;

  logic [ACC_W-1:0]       prod_ext;
  logic [ACC_W-1:0]       acc_out;

  assign prod_ext = {{(ACC_W-PROD_W){mul_prod[PROD_W-1]}}, mul_prod};

`ifdef DCT_OUT_ROUND_EN
  // Add in one extra bit so the half-LSB bias cannot wrap a large positive acc.
  localparam logic [ACC_W:0] RND_HALF = (ACC_W+1)'(1) << (OUT_SHIFT-1);
  logic [ACC_W:0]        rnd_sum;
  logic signed [ACC_W:0] rnd_shr;
  assign rnd_sum = {acc_q[ACC_W-1], acc_q} + RND_HALF;
  assign rnd_shr = $signed(rnd_sum) >>> OUT_SHIFT;
  assign acc_out = ACC_W'(rnd_shr);
`else
  logic [31:0] unused_out_shift;
  assign unused_out_shift = 32'(OUT_SHIFT);
  assign acc_out = acc_q;
`endif

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    k_d         = k_q;
    acc_d       = acc_q;
    smp_d       = smp_q;
    in_ready_d  = in_ready_q;
    coef_addr_d = coef_addr_q;
    mul_start_d = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_rst_d   = 1'b1;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    busy_d      = busy_q;
    unique case (state_q)
      S_LOAD: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          smp_d[n_q] = in_data;
          n_d        = n_q + 3'd1;
          if (n_q == 3'd7) begin
            n_d         = 3'd0;
            k_d         = 3'd0;
            acc_d       = '0;
            in_ready_d  = 1'b0;
            coef_addr_d = 6'd0;
            busy_d      = 1'b1;
            state_d     = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        mul_a_d     = smp_q[n_q];
        mul_b_d     = coef_data;
        mul_start_d = 1'b1;
        state_d     = S_START;
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (mul_done) begin
          acc_d     = acc_q + prod_ext;
          mul_rst_d = 1'b0;
          state_d   = S_ACC;
        end
      end
      S_ACC: begin
        if (n_q == 3'd7) begin
          out_valid_d = 1'b1;
          out_data_d  = acc_out;
          out_idx_d   = k_q;
          state_d     = S_EMIT;
        end else begin
          n_d         = n_q + 3'd1;
          coef_addr_d = {k_q, n_q + 3'd1};
          state_d     = S_FETCH;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          n_d         = 3'd0;
          if (k_q == 3'd7) begin
            in_ready_d = 1'b1;
            busy_d     = 1'b0;
            state_d    = S_LOAD;
          end else begin
            k_d         = k_q + 3'd1;
            acc_d       = '0;
            coef_addr_d = {k_q + 3'd1, 3'd0};
            state_d     = S_FETCH;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_LOAD;
      n_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      smp_q       <= '0;
      in_ready_q  <= 1'b0;
      coef_addr_q <= '0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_rst_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      smp_q       <= smp_d;
      in_ready_q  <= in_ready_d;
      coef_addr_q <= coef_addr_d;
      mul_start_q <= mul_start_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_rst_q   <= mul_rst_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign coef_addr = coef_addr_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_rst   = mul_rst_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign busy      = busy_q;

endmodule
